// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: format codes, encoder
// state codes and MIPS instruction field bit positions.
package instr_encoder_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_RSV = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } enc_state_e;

  localparam int OPC_HI = 31;
  localparam int RS_HI  = 25;
  localparam int RT_HI  = 20;
  localparam int RD_HI  = 15;
  localparam int SH_HI  = 10;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: selects the R/I/J layout from fmt and assembles
// the 32-bit MIPS instruction word. Reserved formats produce zero.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  func,
  input  logic [15:0] imm,
  input  logic [25:0] jump_target,
  output logic [31:0] word,
  output logic        rsv
);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    word = '0;
    rsv  = 1'b0;
    word[OPC_HI -: 6] = opcode;
    case (fmt)
      FMT_R: begin
        word[RS_HI -: 5] = rs;
        word[RT_HI -: 5] = rt;
        word[RD_HI -: 5] = rd;
        word[SH_HI -: 5] = shamt;
        word[5:0]        = func;
      end
      FMT_I: begin
        word[RS_HI -: 5] = rs;
        word[RT_HI -: 5] = rt;
        word[15:0]       = imm;
      end
      FMT_J: word[25:0] = jump_target;
      default: begin
        word = '0;
        rsv  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program-memory loader: accepts instruction field bundles over valid/ready,
// packs them and writes one word every two cycles starting at address 0.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        func,
  input  logic [15:0]       imm,
  input  logic [25:0]       jump_target,
  input  logic              last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              full,
  output logic              error
);

  enc_state_e  state, state_next;
  logic [31:0] packed_word;
  logic        fmt_rsv;
  logic        last_q;
  logic        do_clear, do_load, do_write, set_err;

  instr_pack u_pack (
    .fmt         (fmt),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .func        (func),
    .imm         (imm),
    .jump_target (jump_target),
    .word        (packed_word),
    .rsv         (fmt_rsv)
  );

  always_comb begin
    state_next = state;
    do_clear   = 1'b0;
    do_load    = 1'b0;
    do_write   = 1'b0;
    set_err    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          do_clear   = 1'b1;
          state_next = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (in_valid) begin
          if (fmt_rsv) begin
            set_err = 1'b1;
            if (last) state_next = ST_DONE;
          end else begin
            do_load    = 1'b1;
            state_next = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        do_write   = 1'b1;
        state_next = (mem_addr == '1 || last_q) ? ST_DONE : ST_ACCEPT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Handshake/strobe outputs are registered decodes of the next state,
  // so they track the state register with no path from in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      done      <= 1'b0;
      full      <= 1'b0;
      error     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      last_q    <= 1'b0;
    end else begin
      in_ready <= (state_next == ST_ACCEPT);
      mem_we   <= (state_next == ST_WRITE);
      done     <= (state_next == ST_DONE);
      if (do_clear) begin
        mem_addr <= '0;
        count    <= '0;
        full     <= 1'b0;
        error    <= 1'b0;
      end
      if (set_err) error <= 1'b1;
      if (do_load) begin
        mem_wdata <= packed_word;
        last_q    <= last;
      end
      if (do_write) begin
        count    <= count + 1'b1;
        mem_addr <= mem_addr + 1'b1;
        if (mem_addr == '1) full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default-depth instance (a) and a
// 4-word instance (b) for the memory-full case, with hand-computed words.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  fmt = '0;
  logic [5:0]  opcode = '0, func = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [15:0] imm = '0;
  logic [25:0] jump_target = '0;
  logic        last = 1'b0;

  logic        in_ready_a, mem_we_a, done_a, full_a, error_a;
  logic [4:0]  mem_addr_a;
  logic [31:0] mem_wdata_a;
  logic [5:0]  count_a;
  logic        in_ready_b, mem_we_b, done_b, full_b, error_b;
  logic [1:0]  mem_addr_b;
  logic [31:0] mem_wdata_b;
  logic [2:0]  count_b;

  int passed = 0;
  int total  = 0;

  int          log_addr_a[$], log_addr_b[$];
  logic [31:0] log_data_a[$], log_data_b[$];

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(5)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_ready(in_ready_a),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
    .imm(imm), .jump_target(jump_target), .last(last), .mem_we(mem_we_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .count(count_a), .done(done_a),
    .full(full_a), .error(error_a)
  );

  instr_encoder #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_ready(in_ready_b),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
    .imm(imm), .jump_target(jump_target), .last(last), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .count(count_b), .done(done_b),
    .full(full_b), .error(error_b)
  );

  // Write strobes are sampled mid-cycle, away from the edge that launches them.
  always @(negedge clk) begin
    if (mem_we_a) begin
      log_addr_a.push_back(int'(mem_addr_a));
      log_data_a.push_back(mem_wdata_a);
    end
    if (mem_we_b) begin
      log_addr_b.push_back(int'(mem_addr_b));
      log_data_b.push_back(mem_wdata_b);
    end
  end

  task automatic pulse_start(input bit to_b);
    @(negedge clk);
    if (to_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Waits (bounded) for in_ready, then presents one bundle for one edge.
  // Returns at the accept edge + 1 time unit.
  task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s, t, d, sh,
                      input logic [5:0] fn, input logic [15:0] im, input logic [25:0] j,
                      input logic l, input bit to_b, output bit accepted);
    accepted = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (to_b ? in_ready_b : in_ready_a) begin
        fmt = f; opcode = op; rs = s; rt = t; rd = d; shamt = sh;
        func = fn; imm = im; jump_target = j; last = l;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        accepted = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    #22;
    total++; if ({in_ready_a, mem_we_a, done_a, full_a, error_a} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {in_ready_a, mem_we_a, done_a, full_a, error_a}); else passed++;
    total++; if (count_a !== 6'd0) $display("FAIL reset_count: got %0d want 0", count_a); else passed++;
    total++; if (mem_addr_a !== 5'd0) $display("FAIL reset_addr: got %0d want 0", mem_addr_a); else passed++;
    total++; if (mem_wdata_a !== 32'h0) $display("FAIL reset_wdata: got %h want 00000000", mem_wdata_a); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_r_word;
    bit acc;
    int base = log_addr_a.size();
    pulse_start(1'b0);
    total++; if (in_ready_a !== 1'b1) $display("FAIL r_ready: got %b want 1", in_ready_a); else passed++;
    send(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b1, 1'b0, acc);
    total++; if (acc !== 1'b1) $display("FAIL r_accept_timeout: got %b want 1", acc); else passed++;
    total++; if (mem_we_a !== 1'b1) $display("FAIL r_we: got %b want 1", mem_we_a); else passed++;
    total++; if (mem_addr_a !== 5'd0) $display("FAIL r_addr: got %0d want 0", mem_addr_a); else passed++;
    total++; if (mem_wdata_a !== 32'h00221820) $display("FAIL r_wdata: got %h want 00221820", mem_wdata_a); else passed++;
    total++; if (count_a !== 6'd0) $display("FAIL r_count_before: got %0d want 0", count_a); else passed++;
    @(posedge clk); #1;
    total++; if (mem_we_a !== 1'b0) $display("FAIL r_we_one_cycle: got %b want 0", mem_we_a); else passed++;
    total++; if (count_a !== 6'd1) $display("FAIL r_count_after: got %0d want 1", count_a); else passed++;
    total++; if ({done_a, in_ready_a} !== 2'b10) $display("FAIL r_done: got %b want 10", {done_a, in_ready_a}); else passed++;
    total++; if (log_addr_a.size() - base !== 1) $display("FAIL r_writes: got %0d want 1", log_addr_a.size() - base); else passed++;
  endtask

  task automatic test_reserved;
    bit acc;
    int base = log_addr_a.size();
    pulse_start(1'b0);
    send(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0, 1'b0, acc);
    send(2'd3, 6'h3f, 5'h1f, 5'h1f, 5'h1f, 5'h1f, 6'h3f, 16'hffff, 26'h3ffffff, 1'b0, 1'b0, acc);
    total++; if ({mem_we_a, error_a, in_ready_a} !== 3'b011) $display("FAIL rsv_after: got %b want 011", {mem_we_a, error_a, in_ready_a}); else passed++;
    send(2'd0, 6'd0, 5'd3, 5'd1, 5'd4, 5'd0, 6'h22, 16'h0, 26'h0, 1'b1, 1'b0, acc);
    @(posedge clk); #1;
    total++; if (log_addr_a.size() - base !== 2) $display("FAIL rsv_writes: got %0d want 2", log_addr_a.size() - base); else passed++;
    if (log_addr_a.size() - base >= 2) begin
      total++; if (log_addr_a[base] !== 0 || log_data_a[base] !== 32'h00221820) $display("FAIL rsv_word0: got %0d/%h want 0/00221820", log_addr_a[base], log_data_a[base]); else passed++;
      total++; if (log_addr_a[base+1] !== 1 || log_data_a[base+1] !== 32'h00612022) $display("FAIL rsv_word1: got %0d/%h want 1/00612022", log_addr_a[base+1], log_data_a[base+1]); else passed++;
    end
    total++; if ({count_a, done_a, error_a} !== {6'd2, 2'b11}) $display("FAIL rsv_status: got %0d/%b%b want 2/11", count_a, done_a, error_a); else passed++;
  endtask

  task automatic test_i_j;
    bit acc;
    int base = log_addr_a.size();
    pulse_start(1'b0);
    total++; if (error_a !== 1'b0) $display("FAIL ij_error_cleared: got %b want 0", error_a); else passed++;
    send(2'd1, 6'h08, 5'd0, 5'd5, 5'h1f, 5'h1f, 6'h3f, 16'h0010, 26'h3ffffff, 1'b0, 1'b0, acc);
    send(2'd2, 6'h02, 5'h1f, 5'h1f, 5'h1f, 5'h1f, 6'h3f, 16'hffff, 26'h0000040, 1'b1, 1'b0, acc);
    @(posedge clk); #1;
    total++; if (log_addr_a.size() - base !== 2) $display("FAIL ij_writes: got %0d want 2", log_addr_a.size() - base); else passed++;
    if (log_addr_a.size() - base >= 2) begin
      total++; if (log_addr_a[base] !== 0 || log_data_a[base] !== 32'h20050010) $display("FAIL ij_word0: got %0d/%h want 0/20050010", log_addr_a[base], log_data_a[base]); else passed++;
      total++; if (log_addr_a[base+1] !== 1 || log_data_a[base+1] !== 32'h08000040) $display("FAIL ij_word1: got %0d/%h want 1/08000040", log_addr_a[base+1], log_data_a[base+1]); else passed++;
    end
    total++; if ({count_a, done_a} !== {6'd2, 1'b1}) $display("FAIL ij_status: got %0d/%b want 2/1", count_a, done_a); else passed++;
  endtask

  task automatic test_fill;
    bit acc;
    int base = log_addr_b.size();
    pulse_start(1'b1);
    for (int i = 0; i < 5; i++) begin
      send(2'd0, 6'd0, 5'd1, 5'd2, 5'(i), 5'd0, 6'h20, 16'h0, 26'h0, 1'b0, 1'b1, acc);
      total++; if (acc !== (i < 4)) $display("FAIL fill_accept%0d: got %b want %b", i, acc, (i < 4)); else passed++;
    end
    total++; if (log_addr_b.size() - base !== 4) $display("FAIL fill_writes: got %0d want 4", log_addr_b.size() - base); else passed++;
    for (int i = 0; i < 4 && base + i < log_addr_b.size(); i++) begin
      total++; if (log_addr_b[base+i] !== i || log_data_b[base+i] !== (32'h00220020 | (i << 11))) $display("FAIL fill_word%0d: got %0d/%h want %0d/%h", i, log_addr_b[base+i], log_data_b[base+i], i, 32'h00220020 | (i << 11)); else passed++;
    end
    total++; if ({full_b, done_b, in_ready_b} !== 3'b110) $display("FAIL fill_flags: got %b want 110", {full_b, done_b, in_ready_b}); else passed++;
    total++; if (count_b !== 3'd4) $display("FAIL fill_count: got %0d want 4", count_b); else passed++;
  endtask

  task automatic test_reset_mid_write;
    bit acc;
    int base = log_addr_a.size();
    pulse_start(1'b0);
    send(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0, 1'b0, acc);
    send(2'd0, 6'd0, 5'd3, 5'd1, 5'd4, 5'd0, 6'h22, 16'h0, 26'h0, 1'b0, 1'b0, acc);
    total++; if ({mem_we_a, mem_addr_a} !== {1'b1, 5'd1}) $display("FAIL rmw_pre: got %b/%0d want 1/1", mem_we_a, mem_addr_a); else passed++;
    #1 rst = 1'b1;
    #1;
    total++; if ({in_ready_a, mem_we_a, done_a, full_a, error_a} !== 5'b0) $display("FAIL rmw_flags: got %b want 00000", {in_ready_a, mem_we_a, done_a, full_a, error_a}); else passed++;
    total++; if ({count_a, mem_addr_a, mem_wdata_a} !== '0) $display("FAIL rmw_regs: got %0d/%0d/%h want 0/0/0", count_a, mem_addr_a, mem_wdata_a); else passed++;
    total++; if (dut_a.state !== 2'd0) $display("FAIL rmw_state: got %0d want 0", dut_a.state); else passed++;
    @(negedge clk);
    rst = 1'b0;
    pulse_start(1'b0);
    send(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b1, 1'b0, acc);
    @(posedge clk); #1;
    total++; if (log_addr_a.size() - base !== 2) $display("FAIL rmw_writes: got %0d want 2", log_addr_a.size() - base); else passed++;
    if (log_addr_a.size() - base >= 2) begin
      total++; if (log_addr_a[base+1] !== 0) $display("FAIL rmw_restart_addr: got %0d want 0", log_addr_a[base+1]); else passed++;
    end
  endtask

  task automatic test_start_ignored;
    bit acc;
    int base = log_addr_a.size();
    pulse_start(1'b0);
    send(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0, 1'b0, acc);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    pulse_start(1'b0);
    total++; if ({count_a, mem_addr_a} !== {6'd1, 5'd1}) $display("FAIL ign_start: got %0d/%0d want 1/1", count_a, mem_addr_a); else passed++;
    total++; if ({in_ready_a, done_a} !== 2'b10) $display("FAIL ign_start_state: got %b want 10", {in_ready_a, done_a}); else passed++;
    send(2'd0, 6'd0, 5'd3, 5'd1, 5'd4, 5'd0, 6'h22, 16'h0, 26'h0, 1'b1, 1'b0, acc);
    @(posedge clk); #1;
    in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++; if ({mem_we_a, done_a, in_ready_a, count_a} !== {3'b010, 6'd2}) $display("FAIL ign_valid_done: got %b%b%b/%0d want 010/2", mem_we_a, done_a, in_ready_a, count_a); else passed++;
    in_valid = 1'b0;
    total++; if (log_addr_a.size() - base !== 2) $display("FAIL ign_writes: got %0d want 2", log_addr_a.size() - base); else passed++;
    if (log_addr_a.size() - base >= 2) begin
      total++; if (log_addr_a[base+1] !== 1) $display("FAIL ign_addr1: got %0d want 1", log_addr_a[base+1]); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_r_word();
    test_reserved();
    test_i_j();
    test_fill();
    test_reset_mid_write();
    test_start_ignored();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
